bram_stream_reader: RTL and testbench

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

---
 rtl/bram_stream_reader_pkg.sv | 15 +
 rtl/bram_stream_reader_sync_fifo.sv | 68 ++++++
 rtl/bram_stream_reader.sv | 144 ++++++++++++++
 tb/tb_bram_stream_reader.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_stream_reader_pkg.sv
// Shared types and constants for the BRAM stream reader.
package bram_stream_reader_pkg;

  // Burst controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Cycles from ram_enb to valid ram_doutb (enb -> regceb -> data).
  localparam int unsigned RD_LATENCY = 2;

endpackage

// File: rtl/bram_stream_reader_sync_fifo.sv
// Small synchronous FIFO used as the output buffer of the stream reader.
// Push and pop may happen in the same cycle, also when full: the pop frees
// the slot that the push then fills. Output data reads as zero when empty.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the buffer.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful below count_q.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign valid_o = ~empty;
  assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a burst of consecutive words from a BRAM port B (read latency 2,
// output register enabled by regceb) and streams them out in address order.
// Reads are only issued while the FIFO plus reads still in flight leave a
// free slot, so the output buffer can never overflow under backpressure.
//
// Stream handshake: m_valid_o is high whenever a word is buffered; a word is
// transferred in every cycle where m_valid_o and m_ready_i are both high.
// m_data_o/m_last_o hold steady while m_valid_o is high and m_ready_i is low.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LINES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [ADDR_LINES-1:0] base_addr_i,
  input  logic [ADDR_LINES:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_LINES-1:0] ram_addrb_o,
  output logic                  ram_enb_o,
  output logic                  ram_regceb_o,
  output logic                  ram_rstnb_o,
  input  logic [DATA_WIDTH-1:0] ram_doutb_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i,
  output state_e                dbg_state_o
);

  localparam int LW = ADDR_LINES + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e                  state_q, state_d;
  logic [ADDR_LINES-1:0]   addr_q, addr_d;
  logic [LW-1:0]           len_q, len_d;
  logic [LW-1:0]           issued_q, issued_d;
  logic [RD_LATENCY-1:0]   pipe_vld_q, pipe_vld_d;
  logic [RD_LATENCY-1:0]   pipe_last_q, pipe_last_d;

  logic                    issue, issue_last, credit_ok;
  logic [CW-1:0]           fifo_count, in_flight;
  logic                    fifo_valid, fifo_pop;
  logic [DATA_WIDTH:0]     fifo_dout;

  // Count reads issued to the RAM whose data has not yet reached the FIFO.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      in_flight = in_flight + CW'(pipe_vld_q[i]);
    end
  end

  assign credit_ok = (fifo_count + in_flight) < CW'(FIFO_DEPTH);

  // Burst FSM next-state, read issue and counter updates.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d   = base_addr_i;
          len_d    = len_i;
          issued_d = '0;
          state_d  = (len_i == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if ((issued_q < len_q) && credit_ok) begin
          issue      = 1'b1;
          issue_last = (issued_q == (len_q - LW'(1)));
          addr_d     = addr_q + ADDR_LINES'(1);
          issued_d   = issued_q + LW'(1);
          if (issue_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((in_flight == '0) && !fifo_valid) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    pipe_vld_d  = {pipe_vld_q[RD_LATENCY-2:0], issue};
    pipe_last_d = {pipe_last_q[RD_LATENCY-2:0], issue_last};
  end

  // State, counters and read-latency pipe; reset discards any open burst.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
    end
  end

  assign fifo_pop = fifo_valid & m_ready_i;

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (pipe_vld_q[RD_LATENCY-1]),
    .data_i  ({pipe_last_q[RD_LATENCY-1], ram_doutb_i}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign ram_addrb_o  = addr_q;
  assign ram_enb_o    = issue;
  assign ram_regceb_o = pipe_vld_q[0];
  assign ram_rstnb_o  = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign m_data_o     = fifo_dout[DATA_WIDTH-1:0];
  assign m_last_o     = fifo_dout[DATA_WIDTH];
  assign m_valid_o    = fifo_valid;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: behavioural BRAM, stream monitor and a
// reference model that lists the words/addresses each burst must produce.
module tb_bram_stream_reader;
  import bram_stream_reader_pkg::*;

  localparam int DW    = 32;
  localparam int AL    = 4;
  localparam int FD    = 4;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          start;
  logic [AL-1:0] base;
  logic [AL:0]   len;
  logic          busy, done, enb, regceb, rstnb, m_valid, m_last, m_ready;
  logic [AL-1:0] addrb;
  logic [DW-1:0] doutb, m_data;
  state_e        dbg_state;

  bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_LINES(AL), .FIFO_DEPTH(FD)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .start_i      (start),
    .base_addr_i  (base),
    .len_i        (len),
    .busy_o       (busy),
    .done_o       (done),
    .ram_addrb_o  (addrb),
    .ram_enb_o    (enb),
    .ram_regceb_o (regceb),
    .ram_rstnb_o  (rstnb),
    .ram_doutb_i  (doutb),
    .m_data_o     (m_data),
    .m_valid_o    (m_valid),
    .m_last_o     (m_last),
    .m_ready_i    (m_ready),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- BRAM model, latency 2 ----------------
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_lat;
  always @(posedge clk) begin
    if (enb) ram_lat <= mem[addrb];
    if (!rstnb) doutb <= '0;
    else if (regceb) doutb <= ram_lat;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  logic [DW:0]   got_q[$];
  logic [AL-1:0] addr_q[$];
  int enb_cyc_q[$], xfer_cyc_q[$], done_cyc_q[$];
  int n_vld = 0, out_cnt = 0, max_out = 0, regce_err = 0, rstnb_err = 0;
  logic prev_enb = 1'b0;

  always @(negedge clk) begin
    if (!rstn) begin
      out_cnt  = 0;
      prev_enb = 1'b0;
    end else begin
      if (regceb !== prev_enb) regce_err++;
      if (rstnb !== (busy && !done)) rstnb_err++;
      if (enb) begin
        addr_q.push_back(addrb);
        enb_cyc_q.push_back(cyc);
      end
      if (m_valid) n_vld++;
      if (m_valid && m_ready) begin
        got_q.push_back({m_last, m_data});
        xfer_cyc_q.push_back(cyc);
      end
      if (done) done_cyc_q.push_back(cyc);
      out_cnt = out_cnt + int'(enb) - int'(m_valid && m_ready);
      if (out_cnt > max_out) max_out = out_cnt;
      prev_enb = enb;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0, n_err = 0;
  int start_cyc = 0;
  logic [DW:0]   exp_q[$];
  logic [AL-1:0] exp_addr[$];

  // Expected stream: len words from base upward, wrapping, last on the final one.
  task automatic build_exp(input int b, input int l);
    exp_q.delete();
    exp_addr.delete();
    for (int i = 0; i < l; i++) begin
      int a;
      a = (b + i) % DEPTH;
      exp_addr.push_back(AL'(a));
      exp_q.push_back({(i == l - 1), mem[a]});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input int b, input int l);
    @(posedge clk); #1;
    start = 1'b1;
    base  = AL'(b);
    len   = (AL+1)'(l);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int pct, output bit ok);
    int d0;
    d0 = done_cyc_q.size();
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      m_ready = ($urandom_range(0, 99) < pct);
      @(negedge clk); #1;
      if (done_cyc_q.size() > d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic fill_mem_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [42:0] outs;
    rstn = 1'b0; start = 1'b0; base = '0; len = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    outs = {busy, done, m_valid, m_last, enb, regceb, rstnb, addrb, m_data};
    n_cmp++;
    if (outs !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h required 0", outs);
    end
    n_cmp++;
    if (dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    int g0, e0, x0, d0, lat;
    bit ok;
    logic [DW:0] act;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 10);
    g0 = got_q.size(); e0 = enb_cyc_q.size(); x0 = xfer_cyc_q.size(); d0 = done_cyc_q.size();
    build_exp(3, 4);
    m_ready = 1'b1;
    do_start(3, 4);
    wait_done(100, 100, ok);
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL basic_timeout: no done within budget"); end
    n_cmp++;
    if (got_q.size() - g0 != 4) begin
      n_err++; $display("FAIL basic_count: got %0d words required 4", got_q.size() - g0);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (g0 + i < got_q.size()) ? got_q[g0 + i] : 'x;
      n_cmp++;
      if (act !== exp_q[i]) begin
        n_err++; $display("FAIL basic_word%0d: got %h required %h", i, act, exp_q[i]);
      end
    end
    lat = (enb_cyc_q.size() > e0 && xfer_cyc_q.size() > x0) ? xfer_cyc_q[x0] - enb_cyc_q[e0] : -1;
    n_cmp++;
    if (lat < 2 || lat > 3) begin
      n_err++; $display("FAIL basic_latency: got %0d required 2..3 cycles", lat);
    end
    n_cmp++;
    if (done_cyc_q.size() - d0 != 1) begin
      n_err++; $display("FAIL basic_done_pulses: got %0d required 1", done_cyc_q.size() - d0);
    end
  endtask

  task automatic test_wrap();
    int g0, a0;
    bit ok;
    logic [AL-1:0] acta;
    logic [DW:0] act;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 10);
    g0 = got_q.size(); a0 = addr_q.size();
    build_exp(14, 4);
    m_ready = 1'b1;
    do_start(14, 4);
    wait_done(100, 100, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL wrap_timeout: no done within budget"); end
    for (int i = 0; i < exp_addr.size(); i++) begin
      acta = (a0 + i < addr_q.size()) ? addr_q[a0 + i] : 'x;
      n_cmp++;
      if (acta !== exp_addr[i]) begin
        n_err++; $display("FAIL wrap_addr%0d: got %0d required %0d", i, acta, exp_addr[i]);
      end
      act = (g0 + i < got_q.size()) ? got_q[g0 + i] : 'x;
      n_cmp++;
      if (act !== exp_q[i]) begin
        n_err++; $display("FAIL wrap_word%0d: got %h required %h", i, act, exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int g0, e0;
    bit ok;
    logic [DW:0] act;
    fill_mem_random();
    g0 = got_q.size(); e0 = enb_cyc_q.size();
    build_exp(5, 8);
    m_ready = 1'b0;
    do_start(5, 8);
    repeat (20) @(negedge clk);
    #1;
    n_cmp++;
    if (enb_cyc_q.size() - e0 != FD) begin
      n_err++; $display("FAIL bp_issues_stalled: got %0d required %0d", enb_cyc_q.size() - e0, FD);
    end
    n_cmp++;
    if (m_valid !== 1'b1 || got_q.size() != g0) begin
      n_err++; $display("FAIL bp_holding: valid %b transfers %0d required valid 1 transfers 0", m_valid, got_q.size() - g0);
    end
    wait_done(200, 100, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL bp_timeout: no done within budget"); end
    n_cmp++;
    if (got_q.size() - g0 != 8) begin
      n_err++; $display("FAIL bp_count: got %0d words required 8", got_q.size() - g0);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (g0 + i < got_q.size()) ? got_q[g0 + i] : 'x;
      n_cmp++;
      if (act !== exp_q[i]) begin
        n_err++; $display("FAIL bp_word%0d: got %h required %h", i, act, exp_q[i]);
      end
    end
  endtask

  task automatic test_len0();
    int e0, d0, v0, dc;
    bit ok;
    e0 = enb_cyc_q.size(); d0 = done_cyc_q.size(); v0 = n_vld;
    m_ready = 1'b1;
    do_start(7, 0);
    wait_done(20, 100, ok);
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL len0_timeout: no done within budget"); end
    dc = (done_cyc_q.size() > d0) ? done_cyc_q[d0] : -1;
    n_cmp++;
    if (dc != start_cyc + 1) begin
      n_err++; $display("FAIL len0_done_cycle: got %0d required %0d", dc, start_cyc + 1);
    end
    n_cmp++;
    if (enb_cyc_q.size() != e0 || n_vld != v0) begin
      n_err++; $display("FAIL len0_activity: reads %0d valid cycles %0d required 0 and 0", enb_cyc_q.size() - e0, n_vld - v0);
    end
    n_cmp++;
    if (done_cyc_q.size() - d0 != 1) begin
      n_err++; $display("FAIL len0_done_pulses: got %0d required 1", done_cyc_q.size() - d0);
    end
  endtask

  task automatic test_restart();
    int g0, e0, d0;
    bit ok;
    logic [DW:0] act;
    fill_mem_random();
    g0 = got_q.size(); e0 = enb_cyc_q.size(); d0 = done_cyc_q.size();
    build_exp(2, 6);
    m_ready = 1'b0;
    do_start(2, 6);
    repeat (2) @(posedge clk);
    do_start(9, 3);
    wait_done(300, 60, ok);
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL restart_timeout: no done within budget"); end
    n_cmp++;
    if (got_q.size() - g0 != 6 || enb_cyc_q.size() - e0 != 6) begin
      n_err++; $display("FAIL restart_count: words %0d reads %0d required 6 and 6", got_q.size() - g0, enb_cyc_q.size() - e0);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (g0 + i < got_q.size()) ? got_q[g0 + i] : 'x;
      n_cmp++;
      if (act !== exp_q[i]) begin
        n_err++; $display("FAIL restart_word%0d: got %h required %h", i, act, exp_q[i]);
      end
    end
    n_cmp++;
    if (done_cyc_q.size() - d0 != 1) begin
      n_err++; $display("FAIL restart_done_pulses: got %0d required 1", done_cyc_q.size() - d0);
    end
  endtask

  task automatic test_reset_mid();
    int e0, d0, g0;
    bit ok;
    logic [42:0] outs;
    logic [DW:0] act;
    fill_mem_random();
    e0 = enb_cyc_q.size();
    m_ready = 1'b0;
    do_start(0, 8);
    for (int c = 0; c < 50 && (enb_cyc_q.size() - e0 < 3); c++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    outs = {busy, done, m_valid, m_last, enb, regceb, rstnb, addrb, m_data};
    n_cmp++;
    if (outs !== '0) begin
      n_err++; $display("FAIL midreset_outputs: got %h required 0", outs);
    end
    n_cmp++;
    if (dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL midreset_state: got %0d required %0d", dbg_state, ST_IDLE);
    end
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    m_ready = 1'b1;
    d0 = done_cyc_q.size(); g0 = got_q.size();
    repeat (10) @(negedge clk);
    #1;
    n_cmp++;
    if (done_cyc_q.size() != d0 || got_q.size() != g0) begin
      n_err++; $display("FAIL midreset_residue: done %0d words %0d required 0 and 0", done_cyc_q.size() - d0, got_q.size() - g0);
    end
    build_exp(11, 2);
    do_start(11, 2);
    wait_done(100, 100, ok);
    n_cmp++;
    if (!ok || got_q.size() - g0 != 2) begin
      n_err++; $display("FAIL midreset_followup: done %b words %0d required 1 and 2", ok, got_q.size() - g0);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (g0 + i < got_q.size()) ? got_q[g0 + i] : 'x;
      n_cmp++;
      if (act !== exp_q[i]) begin
        n_err++; $display("FAIL midreset_word%0d: got %h required %h", i, act, exp_q[i]);
      end
    end
  endtask

  task automatic test_throughput();
    int g0, x0, span, b;
    bit ok;
    logic [DW:0] act;
    fill_mem_random();
    b = $urandom_range(0, DEPTH - 1);
    g0 = got_q.size(); x0 = xfer_cyc_q.size();
    build_exp(b, DEPTH);
    m_ready = 1'b1;
    do_start(b, DEPTH);
    wait_done(200, 100, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL tput_timeout: no done within budget"); end
    span = (xfer_cyc_q.size() - x0 == DEPTH) ? xfer_cyc_q[x0 + DEPTH - 1] - xfer_cyc_q[x0] : -1;
    n_cmp++;
    if (span != DEPTH - 1) begin
      n_err++; $display("FAIL tput_span: got %0d cycles required %0d", span, DEPTH - 1);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (g0 + i < got_q.size()) ? got_q[g0 + i] : 'x;
      n_cmp++;
      if (act !== exp_q[i]) begin
        n_err++; $display("FAIL tput_word%0d: got %h required %h", i, act, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int g0, a0, d0, b, l, pct;
    bit ok;
    logic [DW:0] act;
    logic [AL-1:0] acta;
    for (int t = 0; t < 10; t++) begin
      fill_mem_random();
      b   = $urandom_range(0, DEPTH - 1);
      l   = $urandom_range(1, DEPTH);
      pct = $urandom_range(20, 100);
      g0 = got_q.size(); a0 = addr_q.size(); d0 = done_cyc_q.size();
      build_exp(b, l);
      do_start(b, l);
      wait_done(400, pct, ok);
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if (!ok || done_cyc_q.size() - d0 != 1) begin
        n_err++; $display("FAIL rand%0d_done: done %b pulses %0d required 1 and 1", t, ok, done_cyc_q.size() - d0);
      end
      n_cmp++;
      if (got_q.size() - g0 != l) begin
        n_err++; $display("FAIL rand%0d_count: got %0d words required %0d", t, got_q.size() - g0, l);
      end
      for (int i = 0; i < l; i++) begin
        act  = (g0 + i < got_q.size()) ? got_q[g0 + i] : 'x;
        acta = (a0 + i < addr_q.size()) ? addr_q[a0 + i] : 'x;
        n_cmp++;
        if (act !== exp_q[i] || acta !== exp_addr[i]) begin
          n_err++;
          $display("FAIL rand%0d_word%0d: got %h @%0d required %h @%0d", t, i, act, acta, exp_q[i], exp_addr[i]);
        end
      end
    end
    n_cmp++;
    if (max_out > FD) begin
      n_err++; $display("FAIL credit_limit: got %0d outstanding required <= %0d", max_out, FD);
    end
    n_cmp++;
    if (regce_err != 0) begin
      n_err++; $display("FAIL regceb_timing: got %0d bad cycles required 0", regce_err);
    end
    n_cmp++;
    if (rstnb_err != 0) begin
      n_err++; $display("FAIL rstnb_level: got %0d bad cycles required 0", rstnb_err);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len0();
    test_restart();
    test_reset_mid();
    test_throughput();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
